stop_watch_lap: RTL

- Parametrised next-generation stopwatch/timer core. It keeps a BCD time value HH:MM:SS.cc at 1/100 s resolution and counts up or down.
- Adds a lap-freeze display, a preset load, a countdown expiry flag and an overflow flag.
- Sits between the button synchronisers and the 7-segment display driver. All outputs are registered BCD digits and status flags.

---
 rtl/stop_watch_pkg.sv | 43 ++++
 rtl/stop_watch_lap_if.sv | 29 ++
 rtl/bcd_pair_counter.sv | 79 +++++++
 rtl/stop_watch_lap.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// Shared types, digit limits and preset helpers for the lap stopwatch.
package stop_watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_t;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  localparam int unsigned CS_MAX = 99;
  localparam int unsigned MS_MAX = 59;

  function automatic logic [7:0] split_bcd(input int unsigned value);
    return {bcd_t'(value / 10), bcd_t'(value % 10)};
  endfunction

  // Hours saturate as a whole value; minute/second digits saturate independently.
  function automatic logic [7:0] clamp_field(input bcd_t tens, input bcd_t units,
                                             input bcd_t max_tens, input bcd_t max_units,
                                             input logic whole);
    bcd_t t;
    bcd_t u;
    t = (tens > 4'd9) ? 4'd9 : tens;
    u = (units > 4'd9) ? 4'd9 : units;
    if (whole) begin
      if ((t > max_tens) || ((t == max_tens) && (u > max_units))) begin
        t = max_tens;
        u = max_units;
      end
    end else begin
      if (t > max_tens) t = max_tens;
      if (u > max_units) u = max_units;
    end
    return {t, u};
  endfunction

endpackage

// File: rtl/stop_watch_lap_if.sv
// Control inputs and display/status outputs of the lap stopwatch.
interface stop_watch_lap_if;
  import stop_watch_pkg::*;

  logic        clear;
  logic        start_stop;
  logic        lap;
  logic        mode_down;
  logic        load;
  logic [23:0] preset_bcd;
  bcd_t        hr_h, hr_l, min_h, min_l, sec_h, sec_l, cs_h, cs_l;
  logic        running;
  logic        lap_active;
  logic        ovf;
  logic        expired;

  modport master (
    output clear, start_stop, lap, mode_down, load, preset_bcd,
    input  hr_h, hr_l, min_h, min_l, sec_h, sec_l, cs_h, cs_l,
    input  running, lap_active, ovf, expired
  );

  modport slave (
    input  clear, start_stop, lap, mode_down, load, preset_bcd,
    output hr_h, hr_l, min_h, min_l, sec_h, sec_l, cs_h, cs_l,
    output running, lap_active, ovf, expired
  );

endinterface

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD modulo-(MAX+1) up/down counter; one link of the time cascade.
module bcd_pair_counter
  import stop_watch_pkg::*;
#(
  parameter bcd_t MAX_H = 4'd9,
  parameter bcd_t MAX_L = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dir,
  input  logic load,
  input  bcd_t load_h,
  input  bcd_t load_l,
  input  logic clear,
  output bcd_t val_h,
  output bcd_t val_l,
  output bcd_t nxt_h,
  output bcd_t nxt_l,
  output logic cout,
  output logic at_zero,
  output logic at_max
);

  bcd_t h_q, l_q, h_d, l_d;

  assign at_zero = (h_q == 4'd0) && (l_q == 4'd0);
  assign at_max  = (h_q == MAX_H) && (l_q == MAX_L);
  assign cout    = en && (dir ? at_zero : at_max);

  always_comb begin
    h_d = h_q;
    l_d = l_q;
    if (clear) begin
      h_d = '0;
      l_d = '0;
    end else if (load) begin
      h_d = load_h;
      l_d = load_l;
    end else if (en && !dir) begin
      if (at_max) begin
        h_d = '0;
        l_d = '0;
      end else if (l_q == 4'd9) begin
        h_d = h_q + 4'd1;
        l_d = '0;
      end else begin
        l_d = l_q + 4'd1;
      end
    end else if (en && dir) begin
      // Borrow below zero wraps to the top of the range for this pair.
      if (at_zero) begin
        h_d = MAX_H;
        l_d = MAX_L;
      end else if (l_q == 4'd0) begin
        h_d = h_q - 4'd1;
        l_d = 4'd9;
      end else begin
        l_d = l_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      l_q <= '0;
    end else begin
      h_q <= h_d;
      l_q <= l_d;
    end
  end

  assign val_h = h_q;
  assign val_l = l_q;
  assign nxt_h = h_d;
  assign nxt_l = l_d;

endmodule

// File: rtl/stop_watch_lap.sv
// HH:MM:SS.cc BCD stopwatch/timer with lap freeze, preset load and overflow/expiry flags.
// Button edges are registered once, so every action lands one clock after its edge is seen.
module stop_watch_lap
  import stop_watch_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned HR_MAX      = 99
) (
  input  logic             clk,
  input  logic             rst,
  stop_watch_lap_if.slave  bus
);

  localparam int unsigned CLK_DIV    = CLK_FREQ_HZ / 100;
  localparam int unsigned PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0] HR_BCD = split_bcd(HR_MAX);
  localparam logic [7:0] MS_BCD = split_bcd(MS_MAX);
  localparam logic [7:0] CS_BCD = split_bcd(CS_MAX);

  logic [2:0] lvl, prev_q, prev_d, edge_q, edge_d;
  logic       clear_edge, start_edge, lap_edge;

  run_state_t    state_q, state_d;
  mode_t         mode_q, mode_d;
  logic          lap_active_q, lap_active_d;
  logic          ovf_q, ovf_d;
  logic          expired_q, expired_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   disp_q, disp_d;

  logic tick, tick_go, dir, cnt_clear, cnt_load, lap_capture;
  logic live_zero, reach_zero;
  logic [7:0] hr_cl, min_cl, sec_cl;
  logic [31:0] live_cur, live_nxt;

  bcd_t cc_h, cc_l, ss_h, ss_l, mm_h, mm_l, hh_h, hh_l;
  bcd_t cc_hn, cc_ln, ss_hn, ss_ln, mm_hn, mm_ln, hh_hn, hh_ln;
  logic cc_co, ss_co, mm_co, hh_co;
  logic cc_zero, ss_zero, mm_zero, hh_zero;
  logic cc_max, ss_max, mm_max, hh_max;
  logic unused_at_max;

  assign lvl        = {bus.clear, bus.start_stop, bus.lap};
  assign clear_edge = edge_q[2];
  assign start_edge = edge_q[1];
  assign lap_edge   = edge_q[0];

  always_comb begin
    prev_d = lvl;
    edge_d = lvl & ~prev_q;
  end

  assign hr_cl  = clamp_field(bus.preset_bcd[23:20], bus.preset_bcd[19:16], HR_BCD[7:4], HR_BCD[3:0], 1'b1);
  assign min_cl = clamp_field(bus.preset_bcd[15:12], bus.preset_bcd[11:8],  MS_BCD[7:4], MS_BCD[3:0], 1'b0);
  assign sec_cl = clamp_field(bus.preset_bcd[7:4],   bus.preset_bcd[3:0],   MS_BCD[7:4], MS_BCD[3:0], 1'b0);

  assign dir        = (mode_q == MODE_DOWN);
  assign tick       = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
  assign tick_go    = tick && !clear_edge && !start_edge;
  assign live_zero  = cc_zero && ss_zero && mm_zero && hh_zero;
  assign reach_zero = (cc_h == 4'd0) && (cc_l == 4'd1) && ss_zero && mm_zero && hh_zero;
  assign live_cur   = {hh_h, hh_l, mm_h, mm_l, ss_h, ss_l, cc_h, cc_l};
  assign live_nxt   = {hh_hn, hh_ln, mm_hn, mm_ln, ss_hn, ss_ln, cc_hn, cc_ln};
  // Lower pairs signal their limit through the carry chain; at_max is informational.
  assign unused_at_max = cc_max & ss_max & mm_max & hh_max;

  bcd_pair_counter #(.MAX_H(CS_BCD[7:4]), .MAX_L(CS_BCD[3:0])) u_cc (
    .clk(clk), .rst(rst), .en(tick_go), .dir(dir), .load(cnt_load), .load_h(4'd0), .load_l(4'd0),
    .clear(cnt_clear), .val_h(cc_h), .val_l(cc_l), .nxt_h(cc_hn), .nxt_l(cc_ln),
    .cout(cc_co), .at_zero(cc_zero), .at_max(cc_max)
  );

  bcd_pair_counter #(.MAX_H(MS_BCD[7:4]), .MAX_L(MS_BCD[3:0])) u_ss (
    .clk(clk), .rst(rst), .en(cc_co), .dir(dir), .load(cnt_load), .load_h(sec_cl[7:4]), .load_l(sec_cl[3:0]),
    .clear(cnt_clear), .val_h(ss_h), .val_l(ss_l), .nxt_h(ss_hn), .nxt_l(ss_ln),
    .cout(ss_co), .at_zero(ss_zero), .at_max(ss_max)
  );

  bcd_pair_counter #(.MAX_H(MS_BCD[7:4]), .MAX_L(MS_BCD[3:0])) u_mm (
    .clk(clk), .rst(rst), .en(ss_co), .dir(dir), .load(cnt_load), .load_h(min_cl[7:4]), .load_l(min_cl[3:0]),
    .clear(cnt_clear), .val_h(mm_h), .val_l(mm_l), .nxt_h(mm_hn), .nxt_l(mm_ln),
    .cout(mm_co), .at_zero(mm_zero), .at_max(mm_max)
  );

  bcd_pair_counter #(.MAX_H(HR_BCD[7:4]), .MAX_L(HR_BCD[3:0])) u_hh (
    .clk(clk), .rst(rst), .en(mm_co), .dir(dir), .load(cnt_load), .load_h(hr_cl[7:4]), .load_l(hr_cl[3:0]),
    .clear(cnt_clear), .val_h(hh_h), .val_l(hh_l), .nxt_h(hh_hn), .nxt_l(hh_ln),
    .cout(hh_co), .at_zero(hh_zero), .at_max(hh_max)
  );

  // Priority: clear, then load (stopped only), then start toggle, lap and tick together.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lap_active_d = lap_active_q;
    ovf_d        = ovf_q;
    expired_d    = expired_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    lap_capture  = 1'b0;
    if (clear_edge) begin
      state_d      = ST_STOPPED;
      lap_active_d = 1'b0;
      ovf_d        = 1'b0;
      expired_d    = 1'b0;
      cnt_clear    = 1'b1;
    end else if (bus.load && (state_q == ST_STOPPED)) begin
      cnt_load  = 1'b1;
      ovf_d     = 1'b0;
      expired_d = 1'b0;
    end else begin
      if (start_edge) begin
        if (state_q == ST_RUNNING) begin
          state_d = ST_STOPPED;
        end else if (!(bus.mode_down && live_zero)) begin
          state_d = ST_RUNNING;
          mode_d  = bus.mode_down ? MODE_DOWN : MODE_UP;
        end
      end
      if (lap_edge) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (state_q == ST_RUNNING) begin
          lap_active_d = 1'b1;
          lap_capture  = 1'b1;
        end
      end
      if (tick_go) begin
        if (dir && reach_zero) begin
          state_d   = ST_STOPPED;
          expired_d = 1'b1;
        end
        if (!dir && hh_co) ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clear_edge || start_edge || (state_q != ST_RUNNING) || (presc_q == PRESC_LAST)) begin
      presc_d = '0;
    end
    disp_d = live_nxt;
    if (lap_active_d) disp_d = lap_capture ? live_cur : disp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= lvl;
      edge_q       <= '0;
      state_q      <= ST_STOPPED;
      mode_q       <= MODE_UP;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      expired_q    <= 1'b0;
      presc_q      <= '0;
      disp_q       <= '0;
    end else begin
      prev_q       <= prev_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      lap_active_q <= lap_active_d;
      ovf_q        <= ovf_d;
      expired_q    <= expired_d;
      presc_q      <= presc_d;
      disp_q       <= disp_d;
    end
  end

  assign bus.hr_h       = disp_q[31:28];
  assign bus.hr_l       = disp_q[27:24];
  assign bus.min_h      = disp_q[23:20];
  assign bus.min_l      = disp_q[19:16];
  assign bus.sec_h      = disp_q[15:12];
  assign bus.sec_l      = disp_q[11:8];
  assign bus.cs_h       = disp_q[7:4];
  assign bus.cs_l       = disp_q[3:0];
  assign bus.running    = (state_q == ST_RUNNING);
  assign bus.lap_active = lap_active_q;
  assign bus.ovf        = ovf_q;
  assign bus.expired    = expired_q;

endmodule
